// File: rtl/arg_pkg.sv
// Shared definitions for the streaming arg-min / arg-max selector family.
package arg_pkg;
  localparam int ARG_WIDTH = 8;
  localparam int ARG_N     = 10;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/arg_min_stream.sv
// Serial arg-min over a frame of up to N samples; the result is held until the consumer takes it.
// state | meaning
// SCAN  | accepting samples, tracking running minimum
// HOLD  | result presented on out_*, waiting for out_ready
module arg_min_stream
  import arg_pkg::*;
#(
  parameter int WIDTH = ARG_WIDTH,
  parameter int N     = ARG_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_ind,
  output logic [WIDTH-1:0] out_min,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] run_min;
  logic [IDX_W-1:0] run_ind;

  logic             first_beat;
  logic             take;
  logic             at_end;
  logic             close;
  logic [WIDTH-1:0] beat_min;
  logic [IDX_W-1:0] beat_ind;

  // Running result including the current beat; strict compare keeps the earliest index on ties.
  always_comb begin
    first_beat = (cnt == '0);
    take       = first_beat || (in_data < run_min);
    at_end     = (cnt == LAST_IDX);
    close      = in_last || at_end;
    beat_min   = take ? in_data : run_min;
    beat_ind   = first_beat ? '0 : (take ? cnt : run_ind);
  end

  assign in_ready  = (state == SCAN);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      cnt     <= '0;
      run_min <= '0;
      run_ind <= '0;
      out_ind <= '0;
      out_min <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (in_valid) begin
            run_min <= beat_min;
            run_ind <= beat_ind;
            if (close) begin
              out_min <= beat_min;
              out_ind <= beat_ind;
              out_err <= (in_last != at_end);
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= SCAN;
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_arg_min_stream.sv
// Randomized bench for arg_min_stream against a queue-based frame model.
module tb_arg_min_stream;
  import arg_pkg::*;

  localparam int WIDTH = ARG_WIDTH;
  localparam int N     = ARG_N;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [IDX_W-1:0] out_ind;
  logic [WIDTH-1:0] out_min;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] mq[$];

  arg_min_stream #(.WIDTH(WIDTH), .N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_ind(out_ind), .out_min(out_min), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 32'(guard), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Model: a frame ends on in_last or on its N-th sample; result is the first smallest sample.
  task automatic push_beat(input logic [WIDTH-1:0] d, input logic l, input int bubble_pct);
    int k;
    logic [WIDTH-1:0] e_min;
    int e_ind;
    logic e_err;
    k = ($urandom_range(0, 99) < bubble_pct) ? int'($urandom_range(1, 3)) : 0;
    repeat (k) @(negedge clk);
    send_beat(d, l);
    mq.push_back(d);
    if (l || mq.size() == N) begin
      e_min = mq[0];
      e_ind = 0;
      foreach (mq[i]) if (mq[i] < e_min) begin e_min = mq[i]; e_ind = i; end
      e_err = !(l && mq.size() == N);
      chk("res_valid", 32'(out_valid), 32'(1));
      chk("res_ready_low", 32'(in_ready), 32'(0));
      chk("res_min", 32'(out_min), 32'(e_min));
      chk("res_ind", 32'(out_ind), 32'(e_ind));
      chk("res_err", 32'(out_err), 32'(e_err));
      mq.delete();
      if (out_ready) begin
        @(posedge clk);
        #1;
        chk("valid_one_cycle", 32'(out_valid), 32'(0));
      end
    end else begin
      chk("no_early_result", 32'(out_valid), 32'(0));
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] d[$], input logic last_at_end, input int bubble_pct);
    foreach (d[i]) push_beat(d[i], last_at_end && (i == d.size() - 1), bubble_pct);
  endtask

  initial begin
    logic [WIDTH-1:0] fr[$];
    logic [WIDTH-1:0] h_min;
    logic [IDX_W-1:0] h_ind;
    logic             h_err;
    int len;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_min", 32'(out_min), 32'(0));
    chk("rst_out_ind", 32'(out_ind), 32'(0));
    chk("rst_out_err", 32'(out_err), 32'(0));

    fr = '{7, 3, 9, 3, 12, 5, 8, 1, 4, 6};
    push_frame(fr, 1'b1, 0);

    fr = {};
    repeat (N) fr.push_back(8'h55);
    push_frame(fr, 1'b1, 0);
    fr[2] = 8'h00;
    fr[9] = 8'h00;
    push_frame(fr, 1'b1, 0);

    fr = '{20, 10, 30};
    push_frame(fr, 1'b1, 0);

    // Long frame: forced close after 10 beats, beats 11-12 open the next frame.
    fr = '{50, 49, 48, 47, 46, 45, 44, 43, 42, 41, 30, 35};
    push_frame(fr, 1'b0, 0);
    push_beat(8'd40, 1'b1, 0);

    push_beat(8'd0, 1'b1, 0);

    out_ready = 1'b0;
    fr = {};
    for (int i = 0; i < N; i++) fr.push_back(WIDTH'($urandom_range(1, 255)));
    push_frame(fr, 1'b1, 0);
    h_min = out_min;
    h_ind = out_ind;
    h_err = out_err;
    in_valid = 1'b1;
    in_data  = '0;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_min", 32'(out_min), 32'(h_min));
      chk("bp_ind", 32'(out_ind), 32'(h_ind));
      chk("bp_err", 32'(out_err), 32'(h_err));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    fr = {};
    for (int i = 0; i < N; i++) fr.push_back(WIDTH'(255 - i));
    push_frame(fr, 1'b1, 50);

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        push_beat(WIDTH'($urandom), (i == len - 1) && ($urandom_range(0, 3) != 0), 30);
    end
    if (mq.size() > 0) push_beat(8'hff, 1'b1, 0);

    for (int i = 0; i < 4; i++) push_beat(WIDTH'(i), 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_out_min", 32'(out_min), 32'(0));
    chk("arst_out_ind", 32'(out_ind), 32'(0));
    chk("arst_out_err", 32'(out_err), 32'(0));
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fr = '{90, 80, 70, 60, 65, 75, 85, 95, 61, 99};
    push_frame(fr, 1'b1, 20);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/arg_min_stream.md
# arg_min_stream

Sequential streaming arg-min unit: accepts a frame of up to N unsigned samples, one per cycle over a valid/ready handshake. It returns the index and value of the smallest sample, plus a frame-length error flag, over a second valid/ready handshake. It is the serial, minimum-seeking counterpart of the combinational arg-max selector. It sits between a sample producer (e.g. score/distance stream) and any consumer that needs the winning position per frame.

## Interface
- WIDTH, 8, sample width in bits (unsigned)
- N, 10, nominal frame length in samples (N >= 2)
- IDX_W, $clog2(N), index width (4 for defaults)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  sample
- in_valid  in  1  sample present
- in_last  in  1  final sample of frame (qualified by in_valid)
- in_ready  out  1  block accepts sample this cycle
- out_ind  out  IDX_W  index of minimum sample within frame
- out_min  out  WIDTH  minimum sample value
- out_err  out  1  frame length was not exactly N
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: SCAN, HOLD. Reset state SCAN.
- in_ready = (state == SCAN). out_valid = (state == HOLD).
- Beat accepted when in_valid && in_ready.
- Registers: cnt (IDX_W), run_min (WIDTH), run_ind (IDX_W), out_* regs.
- First beat of frame (cnt == 0): run_min <= in_data, run_ind <= 0.
- Later beat: if in_data < run_min (unsigned, strict), load in_data and cnt. Ties keep the earlier index.
- Each accepted beat increments cnt.
- Frame closes on an accepted beat with in_last = 1 or cnt == N-1. On close:
  - out_min/out_ind are loaded with the result including the current beat.
  - out_err <= (in_last != (cnt == N-1)).
  - cnt <= 0.
  - Go to HOLD.
- Short frame (in_last before the N-th beat): the result covers received samples and out_err = 1.
- Long frame (N-th beat without in_last): the frame is force-closed and out_err = 1. Following beats start a new frame.
- HOLD: out_* stable while out_valid && !out_ready. On out_ready the FSM returns to SCAN.
- A single-beat frame (in_last on the first beat) gives out_ind = 0, out_min = that sample, out_err = 1.

## Timing
- Reset (async assert, sync-to-clk release):
  - state = SCAN, cnt = 0, run_min = 0, run_ind = 0.
  - out_ind = 0, out_min = 0, out_err = 0.
  - out_valid = 0, in_ready = 1.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Throughput: one frame per (frame length + 1) cycles minimum. in_ready is 0 for at least one cycle per frame (the HOLD cycle), even if out_ready is held at 1.
- in_valid low mid-frame inserts bubbles. Partial frame state is retained indefinitely.
- Reset mid-frame or mid-HOLD discards the partial frame and any pending result. No result is emitted.
- Upstream in_data/in_last are only sampled on accepted beats. Values while in_valid = 0 are ignored.

## Structure
- Shared package arg_pkg:
  - state enum type (SCAN, HOLD).
  - default WIDTH/N localparams, reused by the arg-max blocks.
- Single module. No sub-module required; the compare is one unsigned `<` expression.

## Test plan
- Frame 7,3,9,3,12,5,8,1,4,6 with in_last on the 10th beat, out_ready = 1 -> out_min = 1, out_ind = 7, out_err = 0, out_valid for 1 cycle, one cycle after the last beat.
- Tie: all ten samples = 0x55 -> out_ind = 0, out_min = 0x55, out_err = 0. Repeat with minimum 0x00 at indices 2 and 9 -> out_ind = 2.
- Short frame 20,10,30 with in_last on beat 3 -> out_min = 10, out_ind = 1, out_err = 1. Long frame of 12 beats without in_last -> first result covers 10 samples with out_err = 1, next frame starts at beat 11.
- Backpressure: hold out_ready = 0 for 5 cycles after result -> out_* stable, in_ready = 0 throughout. Next frame is accepted only after the out_ready handshake.
- Random in_valid bubbles (50%) over a frame 255,254,…,246 -> out_min = 246, out_ind = 9, out_err = 0.
- Assert rst_n asynchronously after beat 4 of a frame -> all outputs 0 immediately. A fresh 10-beat frame then yields a correct result unaffected by the pre-reset samples.
